// File: rtl/ball_pkg.sv
// Shared constants, FSM state type and saturating-abs helper for the ball
// motion sequencer.
package ball_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_H_INIT    = 320;
  localparam int DEF_V_INIT    = 240;
  localparam int DEF_VEL_W     = 4;

  // Candidate positions carry two extra bits so underflow below 0 is visible.
  localparam int POS_W  = 10;
  localparam int CAND_W = 12;

  localparam int RST_HVEL = -2;
  localparam int RST_VVEL = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    CLAMP = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Control/status bundle between the game logic and the ball motion sequencer.
interface ball_motion_ctrl_if #(
  parameter int VEL_W = ball_pkg::DEF_VEL_W
);
  logic                    vsync;
  logic                    run;
  logic                    step;
  logic                    vel_load;
  logic signed [VEL_W-1:0] vel_h_in;
  logic signed [VEL_W-1:0] vel_v_in;
  logic [9:0]              ball_hpos;
  logic [9:0]              ball_vpos;
  logic signed [VEL_W-1:0] ball_hvel;
  logic signed [VEL_W-1:0] ball_vvel;
  logic                    busy;
  logic                    frame_done;
  logic [1:0]              bounce;
  logic                    overrun;

  modport master (
    output vsync, run, step, vel_load, vel_h_in, vel_v_in,
    input  ball_hpos, ball_vpos, ball_hvel, ball_vvel,
           busy, frame_done, bounce, overrun
  );

  modport slave (
    input  vsync, run, step, vel_load, vel_h_in, vel_v_in,
    output ball_hpos, ball_vpos, ball_hvel, ball_vvel,
           busy, frame_done, bounce, overrun
  );
endinterface

// File: rtl/ball_axis_step.sv
// One axis of ball motion: forms the moved candidate, then clamps it to
// [0, max] and reflects the velocity on a wall hit.
module ball_axis_step
  import ball_pkg::*;
#(
  parameter int VEL_W = DEF_VEL_W
) (
  input  logic [POS_W-1:0]         pos,
  input  logic signed [VEL_W-1:0]  vel,
  input  logic signed [CAND_W-1:0] max,
  input  logic signed [CAND_W-1:0] cand,
  output logic signed [CAND_W-1:0] moved,
  output logic [POS_W-1:0]         next_pos,
  output logic signed [VEL_W-1:0]  next_vel,
  output logic                     bounce
);

  localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};

  logic signed [VEL_W-1:0] mag;

  assign moved = $signed({{(CAND_W-POS_W){1'b0}}, pos})
               + $signed({{(CAND_W-VEL_W){vel[VEL_W-1]}}, vel});

  // The most negative velocity has no positive twin; it saturates instead.
  always_comb begin
    mag = vel;
    if (vel[VEL_W-1]) begin
      if (vel == VEL_MIN) mag = VEL_MAX;
      else                mag = -vel;
    end
  end

  always_comb begin
    next_pos = POS_W'(cand);
    next_vel = vel;
    bounce   = 1'b0;
    if (cand < 0) begin
      next_pos = '0;
      next_vel = mag;
      bounce   = 1'b1;
    end else if (cand > max) begin
      next_pos = POS_W'(max);
      next_vel = -mag;
      bounce   = 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: on a qualified vsync rising edge it moves
// the ball, clamps/reflects against the four walls and reports the result.
//
//   state | meaning
//   IDLE  | waiting for a qualified vsync edge; pending velocity applied here
//   MOVE  | register candidate positions pos + vel for both axes
//   CLAMP | write clamped positions, reflected velocities and bounce flags
//   DONE  | frame_done and bounce presented for one cycle
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int H_INIT    = DEF_H_INIT,
  parameter int V_INIT    = DEF_V_INIT,
  parameter int VEL_W     = DEF_VEL_W
) (
  input logic              clk,
  input logic              reset,
  ball_motion_ctrl_if.slave bus
);

  localparam logic signed [CAND_W-1:0] H_MAX = CAND_W'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [CAND_W-1:0] V_MAX = CAND_W'(V_ACTIVE - BALL_SIZE);

  state_t state, state_nxt;

  logic                     vsync_d;
  logic                     vs_rise;
  logic                     start;
  logic                     step_pending;
  logic                     vel_pending;
  logic                     vel_apply;
  logic signed [VEL_W-1:0]  vel_h_pend, vel_v_pend;
  logic signed [VEL_W-1:0]  vel_h_src, vel_v_src;
  logic [POS_W-1:0]         hpos, vpos;
  logic signed [VEL_W-1:0]  hvel, vvel;
  logic signed [CAND_W-1:0] nx, ny;
  logic [1:0]               bounce_r;
  logic                     overrun_r;

  logic signed [CAND_W-1:0] h_moved, v_moved;
  logic [POS_W-1:0]         h_next_pos, v_next_pos;
  logic signed [VEL_W-1:0]  h_next_vel, v_next_vel;
  logic                     h_bounce, v_bounce;

  assign vs_rise = bus.vsync & ~vsync_d;
  assign start   = vs_rise & (bus.run | step_pending) & (state == IDLE);

  // A load arriving on the apply cycle itself bypasses the pending copy.
  assign vel_apply = (state == IDLE) & ~start & (bus.vel_load | vel_pending);
  assign vel_h_src = bus.vel_load ? bus.vel_h_in : vel_h_pend;
  assign vel_v_src = bus.vel_load ? bus.vel_v_in : vel_v_pend;

  ball_axis_step #(.VEL_W(VEL_W)) u_axis_h (
    .pos      (hpos),
    .vel      (hvel),
    .max      (H_MAX),
    .cand     (nx),
    .moved    (h_moved),
    .next_pos (h_next_pos),
    .next_vel (h_next_vel),
    .bounce   (h_bounce)
  );

  ball_axis_step #(.VEL_W(VEL_W)) u_axis_v (
    .pos      (vpos),
    .vel      (vvel),
    .max      (V_MAX),
    .cand     (ny),
    .moved    (v_moved),
    .next_pos (v_next_pos),
    .next_vel (v_next_vel),
    .bounce   (v_bounce)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MOVE;
      MOVE:    state_nxt = CLAMP;
      CLAMP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d      <= 1'b0;
      step_pending <= 1'b0;
      vel_pending  <= 1'b0;
      vel_h_pend   <= '0;
      vel_v_pend   <= '0;
      hpos         <= POS_W'(H_INIT);
      vpos         <= POS_W'(V_INIT);
      hvel         <= VEL_W'(RST_HVEL);
      vvel         <= VEL_W'(RST_VVEL);
      nx           <= '0;
      ny           <= '0;
      bounce_r     <= 2'b00;
      overrun_r    <= 1'b0;
    end else begin
      vsync_d <= bus.vsync;

      if (bus.step)  step_pending <= 1'b1;
      else if (start) step_pending <= 1'b0;

      if (vs_rise && state != IDLE) overrun_r <= 1'b1;

      if (vel_apply) begin
        hvel        <= vel_h_src;
        vvel        <= vel_v_src;
        vel_pending <= 1'b0;
      end else if (bus.vel_load) begin
        vel_h_pend  <= bus.vel_h_in;
        vel_v_pend  <= bus.vel_v_in;
        vel_pending <= 1'b1;
      end

      if (state == MOVE) begin
        nx <= h_moved;
        ny <= v_moved;
      end

      if (state == CLAMP) begin
        hpos     <= h_next_pos;
        vpos     <= v_next_pos;
        hvel     <= h_next_vel;
        vvel     <= v_next_vel;
        bounce_r <= {v_bounce, h_bounce};
      end
    end
  end

  assign bus.ball_hpos  = hpos;
  assign bus.ball_vpos  = vpos;
  assign bus.ball_hvel  = hvel;
  assign bus.ball_vvel  = vvel;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == DONE);
  assign bus.bounce     = (state == DONE) ? bounce_r : 2'b00;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: an integer reference model predicts
// each frame's result, a monitor compares it when frame_done appears.
module tb_ball_motion_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ball_motion_ctrl_if #(.VEL_W(4)) bus ();

  ball_motion_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int     x;
    int     y;
    int     vx;
    int     vy;
    int     b;
    longint ecyc;
  } exp_t;

  exp_t   q[$];
  exp_t   e;
  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     busy_run = 0;

  int mx, my, mvx, mvy, last_b;
  bit run_m, step_m;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_axis(input int p, input int v, input int lim,
                                     output int np, output int nv, output int b);
    int n, a;
    n = p + v;
    a = (v < 0) ? ((v == -8) ? 7 : -v) : v;
    if (n < 0)        begin np = 0;   nv = a;  b = 1; end
    else if (n > lim) begin np = lim; nv = -a; b = 1; end
    else              begin np = n;   nv = v;  b = 0; end
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; mvx = -2; mvy = 2; step_m = 0; last_b = 0;
  endtask

  task automatic push_frame();
    int nx, ny, nvx, nvy, bx, by;
    exp_t t;
    model_axis(mx, mvx, 632, nx, nvx, bx);
    model_axis(my, mvy, 472, ny, nvy, by);
    mx = nx; my = ny; mvx = nvx; mvy = nvy;
    last_b = by * 2 + bx;
    t.x = mx; t.y = my; t.vx = mvx; t.vy = mvy; t.b = last_b; t.ecyc = cyc;
    q.push_back(t);
  endtask

  // One vsync rising edge; the model decides whether it starts a frame.
  task automatic edge_only();
    bus.vsync = 1'b1;
    if (run_m || step_m) begin
      push_frame();
      step_m = 0;
    end
    tick();
    bus.vsync = 1'b0;
    tick();
  endtask

  task automatic frame();
    edge_only();
    repeat (5) tick();
  endtask

  task automatic load_vel(input int h, input int v);
    bus.vel_load = 1'b1;
    bus.vel_h_in = 4'(h);
    bus.vel_v_in = 4'(v);
    tick();
    bus.vel_load = 1'b0;
    mvx = h; mvy = v;
    check("vel_load_h", int'($signed(bus.ball_hvel)), mvx);
    check("vel_load_v", int'($signed(bus.ball_vvel)), mvy);
  endtask

  task automatic set_run(input bit r);
    run_m = r;
    bus.run = r;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    step_m = 1;
  endtask

  task automatic check_pos(input string name);
    check({name, "_hpos"}, int'(bus.ball_hpos), mx);
    check({name, "_vpos"}, int'(bus.ball_vpos), my);
    check({name, "_hvel"}, int'($signed(bus.ball_hvel)), mvx);
    check({name, "_vvel"}, int'($signed(bus.ball_vvel)), mvy);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_hpos"}, int'(bus.ball_hpos), 320);
    check({name, "_vpos"}, int'(bus.ball_vpos), 240);
    check({name, "_hvel"}, int'($signed(bus.ball_hvel)), -2);
    check({name, "_vvel"}, int'($signed(bus.ball_vvel)), 2);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_frame_done"}, int'(bus.frame_done), 0);
    check({name, "_bounce"}, int'(bus.bounce), 0);
    check({name, "_overrun"}, int'(bus.overrun), 0);
  endtask

  // Monitor: compares every presented frame against the oldest prediction.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.frame_done) begin
        if (q.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("sb_hpos", int'(bus.ball_hpos), e.x);
          check("sb_vpos", int'(bus.ball_vpos), e.y);
          check("sb_hvel", int'($signed(bus.ball_hvel)), e.vx);
          check("sb_vvel", int'($signed(bus.ball_vvel)), e.vy);
          check("sb_bounce", int'(bus.bounce), e.b);
          check("sb_latency", int'(cyc - e.ecyc), 3);
          check("sb_busy_len", busy_run, 3);
        end
      end else if (bus.bounce != 2'b00) begin
        check("bounce_without_done", int'(bus.bounce), 0);
      end
      if (!bus.busy) busy_run = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r;
    reset        = 1'b1;
    bus.vsync    = 1'b0;
    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.vel_load = 1'b0;
    bus.vel_h_in = '0;
    bus.vel_v_in = '0;
    run_m = 0;
    model_reset();
    repeat (3) tick();
    check_reset_vals("rst_held");
    reset = 1'b0;
    tick();
    check_reset_vals("rst_rel");

    // Free-running frames from the reset position.
    set_run(1);
    repeat (3) frame();
    check("run3_hpos", int'(bus.ball_hpos), 314);
    check("run3_vpos", int'(bus.ball_vpos), 246);

    // Left wall with the saturating -8 velocity.
    load_vel(-8, 0);
    n = 0;
    do begin frame(); n++; end while (last_b == 0 && n < 60);
    check("left_hpos", int'(bus.ball_hpos), 0);
    check("left_hvel", int'($signed(bus.ball_hvel)), 7);
    frame();
    check("left_next_hpos", int'(bus.ball_hpos), 7);

    // Bottom wall overshoot, then an exact landing on the wall.
    load_vel(0, 3);
    n = 0;
    do begin frame(); n++; end while (last_b == 0 && n < 100);
    check("bottom_vpos", int'(bus.ball_vpos), 472);
    check("bottom_vvel", int'($signed(bus.ball_vvel)), -3);
    frame();
    load_vel(0, 3);
    frame();
    check("exact_vpos", int'(bus.ball_vpos), 472);
    check("exact_bounce_model", last_b, 0);

    // Paused: edges do nothing until a step is pending.
    set_run(0);
    repeat (5) frame();
    check_pos("paused");
    load_vel(1, -1);
    pulse_step();
    repeat (2) frame();
    check_pos("stepped");

    // Velocity load coincident with start is deferred until after DONE.
    set_run(1);
    bus.vsync    = 1'b1;
    bus.vel_load = 1'b1;
    bus.vel_h_in = 4'(3);
    bus.vel_v_in = 4'(-2);
    push_frame();
    tick();
    bus.vsync    = 1'b0;
    bus.vel_load = 1'b0;
    repeat (6) tick();
    mvx = 3; mvy = -2;
    check_pos("deferred_load");

    // Edge during busy sets the sticky overrun flag.
    check("overrun_before", int'(bus.overrun), 0);
    bus.vsync = 1'b1;
    push_frame();
    tick();
    bus.vsync = 1'b0;
    tick();
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    repeat (6) tick();
    check("overrun_set", int'(bus.overrun), 1);
    frame();
    check("overrun_sticky", int'(bus.overrun), 1);

    // Randomized mix of loads, frames, pause and step.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: load_vel($urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8);
        1, 2, 3: begin
          frame();
          check_pos("rand_frame");
        end
        4: begin set_run($urandom_range(0, 1)); tick(); end
        default: pulse_step();
      endcase
    end

    // Reset asserted while the FSM is in CLAMP.
    set_run(1);
    repeat (6) tick();
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    frame();
    check("post_reset_hpos", int'(bus.ball_hpos), 318);
    check("post_reset_vpos", int'(bus.ball_vpos), 242);

    repeat (4) tick();
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Per-frame motion sequencer for the bouncing-ball sprite.
- On each vsync rising edge it runs a short FSM: move, clamp/reflect on all four walls, report.
- Publishes the ball position and velocity that the sprite/RGB logic consumes.
- Adds run/pause, single-step and runtime velocity loading for the game logic.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- H_INIT, 320, reset X position
- V_INIT, 240, reset Y position
- VEL_W, 4, signed velocity width (two's complement)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- vsync  in  1  vertical sync, same clock domain
- run  in  1  1 = advance every frame; 0 = paused
- step  in  1  one-cycle pulse: advance exactly one frame while paused
- vel_load  in  1  one-cycle pulse: load vel_h_in/vel_v_in
- vel_h_in  in  VEL_W  signed X velocity to load
- vel_v_in  in  VEL_W  signed Y velocity to load
- ball_hpos  out  10  ball X (left edge)
- ball_vpos  out  10  ball Y (top edge)
- ball_hvel  out  VEL_W  current signed X velocity
- ball_vvel  out  VEL_W  current signed Y velocity
- busy  out  1  high while the update FSM is not in IDLE
- frame_done  out  1  one-cycle pulse when an update completes
- bounce  out  2  {v,h} one-cycle pulses, coincident with frame_done
- overrun  out  1  sticky: vsync edge arrived while busy

Behaviour:
- Reset values: hpos=H_INIT, vpos=V_INIT, hvel=-2, vvel=+2, busy=0, frame_done=0, bounce=0, overrun=0, state=IDLE, step_pending=0, vel_pending=0.
- Edge detect: vsync_d<=vsync each cycle; edge = vsync & ~vsync_d.
- step: sets step_pending. start = edge & (run | step_pending) & IDLE. Any start clears step_pending.
- Frame timing, with edge in cycle E:
  - IDLE, E: start seen.
  - MOVE, E+1: register nx = hpos + sext(hvel) and ny = vpos + sext(vvel), each 12-bit signed.
  - CLAMP, E+2: position and velocity written; new values visible from E+3.
  - DONE, E+3: frame_done=1, bounce valid; next state IDLE.
  - busy=1 during E+1..E+3.
- Clamp, per axis, with MAX = ACTIVE-BALL_SIZE (632 for X, 472 for Y):
  - n<0 -> pos=0, vel=+|vel|, bounce bit set.
  - n>MAX -> pos=MAX, vel=-|vel|, bounce bit set.
  - 0<=n<=MAX -> pos=n, vel unchanged, no bounce. Touching 0 or MAX exactly is not a bounce.
- Negation: |-2^(VEL_W-1)| saturates to 2^(VEL_W-1)-1, i.e. -8 -> +7.
- vel_load:
  - Captured into the pending register at any time; a later load overwrites it (last wins).
  - Applied in IDLE on a cycle without start; applied velocity is visible next cycle.
  - A load arriving while busy, or coincident with start, is held and applied on the first non-start IDLE cycle after DONE.
  - Velocity 0 is legal; that axis stays still and never bounces.
- Edge while busy: edge ignored, overrun<=1, held until reset.
- Reset mid-update: FSM returns to IDLE immediately and all registers take reset values. No partial update persists.
- Paused (run=0, no step): outputs hold indefinitely. vel_load still applies.

Decomposition:
- Package ball_pkg holds:
  - H_ACTIVE, V_ACTIVE, BALL_SIZE, VEL_W defaults.
  - The FSM state enum: IDLE, MOVE, CLAMP, DONE.
  - Reset velocity constants.
- Sub-module ball_axis_step: one-axis move, clamp and reflect with saturating negate. Inputs pos, vel, MAX; outputs next_pos, next_vel, bounce. Instantiated twice, X and Y.
- The top module keeps the FSM, edge detect, step/vel pending registers and overrun.

Test Plan:
- Reset, run=1, 3 vsync edges -> after each frame_done: (318,242), (316,244), (314,246). frame_done exactly 3 cycles after each edge; busy high 3 cycles.
- vel_load h=-8, v=0 at hpos=4, then 1 edge -> hpos=0, hvel=+7, bounce=01. Next edge -> hpos=7, no bounce.
- Force vpos=470, vvel=+3, edge -> ny=473>472 -> vpos=472, vvel=-3, bounce=10. Exact landing on 472 from 469 with vvel=+3 -> no bounce.
- run=0: 5 edges -> outputs unchanged, no frame_done. Then step pulse plus 2 edges -> exactly one update.
- Edge asserted at E+2 during busy -> overrun=1 and sticky. vel_load coincident with start -> old velocity used this frame; new velocity visible after DONE.
- Assert reset during CLAMP -> outputs immediately return to reset values; next frame starts cleanly from (320,240).
